// File: rtl/lc3_mem_sequencer_pkg.sv
// Shared LC3 definitions for the memory sequencer.
//   - LC3 word/address widths (defaults for the sequencer parameters)
//   - seq_state_e : sequencer FSM states
//   - mem_op_e    : access type codes presented on mem_op
//   - MS_*        : phase codes driven on mem_state
package lc3_mem_sequencer_pkg;

  localparam int LC3_WORD_W = 16;
  localparam int LC3_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IND,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_READ_IND  = 2'd2,
    OP_WRITE_IND = 2'd3
  } mem_op_e;

  localparam logic [1:0] MS_READ  = 2'b00;
  localparam logic [1:0] MS_WRITE = 2'b01;
  localparam logic [1:0] MS_IND   = 2'b10;
  localparam logic [1:0] MS_IDLE  = 2'b11;

endpackage

// File: rtl/lc3_mem_sequencer.sv
// LC3 memory access sequencer.
// Runs one read, write, read-indirect or write-indirect access against a
// memory that signals the end of each phase with complete_data. Each phase
// (IND, RD, WR) has a wait budget of TIMEOUT cycles; running out of budget
// produces a one-cycle error pulse instead of done.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   start, mem_op        : request and access type (sampled only in IDLE)
//   M_Addr, M_Data       : access/pointer address and store data
//   complete_data        : memory finished the current phase
//   Data_dout            : memory read data
//   Data_addr, Data_din  : memory address / write data (from registers)
//   Data_rd              : 1=read, 0=write strobe (0 only in WR)
//   mem_state            : 00=read, 01=write, 10=indirect addr read, 11=idle
//   memout               : last completed load value
//   busy, done, error    : not-idle, completion pulse, timeout pulse
// Handshake: a phase ends on the first clock edge in that phase where
// complete_data=1; start is acted upon only at an edge seen in IDLE.
module lc3_mem_sequencer
  import lc3_mem_sequencer_pkg::*;
#(
  parameter int DATA_W  = LC3_WORD_W,
  parameter int ADDR_W  = LC3_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mem_op,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  input  logic              complete_data,
  input  logic [DATA_W-1:0] Data_dout,
  output logic [ADDR_W-1:0] Data_addr,
  output logic [DATA_W-1:0] Data_din,
  output logic              Data_rd,
  output logic [1:0]        mem_state,
  output logic [DATA_W-1:0] memout,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ind_wr_q, ind_wr_d;  // indirect op continues as a write
  logic [ADDR_W-1:0] ptr_addr;

  // Pointer fetched in IND becomes the effective address, zero-extended
  // when the address bus is wider than the data bus.
  generate
    if (ADDR_W <= DATA_W) begin : g_ptr_trunc
      assign ptr_addr = Data_dout[ADDR_W-1:0];
    end else begin : g_ptr_zext
      assign ptr_addr = {{(ADDR_W - DATA_W){1'b0}}, Data_dout};
    end
  endgenerate

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      memout_q <= '0;
      cnt_q    <= '0;
      ind_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      memout_q <= memout_d;
      cnt_q    <= cnt_d;
      ind_wr_q <= ind_wr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    memout_d = memout_q;
    cnt_d    = cnt_q;
    ind_wr_d = ind_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = M_Addr;
          data_d   = M_Data;
          ind_wr_d = mem_op[0];
          cnt_d    = '0;
          if (mem_op[1])             state_d = ST_IND;
          else if (mem_op == OP_READ) state_d = ST_RD;
          else                        state_d = ST_WR;
        end
      end
      ST_IND, ST_RD, ST_WR: begin
        if (complete_data) begin
          cnt_d = '0;
          case (state_q)
            ST_IND: begin
              addr_d  = ptr_addr;
              state_d = ind_wr_q ? ST_WR : ST_RD;
            end
            ST_RD: begin
              memout_d = Data_dout;
              state_d  = ST_DONE;
            end
            default: state_d = ST_DONE;
          endcase
        end else if (cnt_q == CNT_LAST) begin
          // Last cycle of the phase budget passed without completion.
          cnt_d   = '0;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    error     = (state_q == ST_ERR);
    Data_rd   = (state_q != ST_WR);
    Data_addr = addr_q;
    Data_din  = data_q;
    memout    = memout_q;
    case (state_q)
      ST_IND:  mem_state = MS_IND;
      ST_RD:   mem_state = MS_READ;
      ST_WR:   mem_state = MS_WRITE;
      default: mem_state = MS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
module tb_lc3_mem_sequencer;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clock;
  logic              reset;
  logic              start;
  logic [1:0]        mem_op;
  logic [ADDR_W-1:0] M_Addr;
  logic [DATA_W-1:0] M_Data;
  logic              complete_data;
  logic [DATA_W-1:0] Data_dout;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic              Data_rd;
  logic [1:0]        mem_state;
  logic [DATA_W-1:0] memout;
  logic              busy;
  logic              done;
  logic              error;

  int tests_run;
  int tests_failed;

  lc3_mem_sequencer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .mem_op       (mem_op),
    .M_Addr       (M_Addr),
    .M_Data       (M_Data),
    .complete_data(complete_data),
    .Data_dout    (Data_dout),
    .Data_addr    (Data_addr),
    .Data_din     (Data_din),
    .Data_rd      (Data_rd),
    .mem_state    (mem_state),
    .memout       (memout),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    start  = 1'b1;
    mem_op = op;
    M_Addr = a;
    M_Data = d;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      $display("FAIL reset_flags: busy=%b done=%b error=%b expected 0 0 0", busy, done, error);
      tests_failed++;
    end
    tests_run++;
    if (Data_rd !== 1'b1 || mem_state !== 2'b11) begin
      $display("FAIL reset_bus: Data_rd=%b mem_state=%b expected 1 11", Data_rd, mem_state);
      tests_failed++;
    end
    tests_run++;
    if (memout !== 16'h0000 || Data_addr !== 16'h0000 || Data_din !== 16'h0000) begin
      $display("FAIL reset_regs: memout=%h addr=%h din=%h expected 0 0 0", memout, Data_addr, Data_din);
      tests_failed++;
    end
  endtask

  task automatic test_read();
    issue(2'd0, 16'h3000, 16'h0000);
    complete_data = 1'b1;
    Data_dout     = 16'hBEEF;
    tests_run++;
    if (Data_rd !== 1'b1 || mem_state !== 2'b00 || busy !== 1'b1 || Data_addr !== 16'h3000) begin
      $display("FAIL read_phase: rd=%b ms=%b busy=%b addr=%h expected 1 00 1 3000",
               Data_rd, mem_state, busy, Data_addr);
      tests_failed++;
    end
    tick();
    complete_data = 1'b0;
    tests_run++;
    if (done !== 1'b1 || memout !== 16'hBEEF || mem_state !== 2'b11 || error !== 1'b0) begin
      $display("FAIL read_done: done=%b memout=%h ms=%b err=%b expected 1 beef 11 0",
               done, memout, mem_state, error);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL read_idle: done=%b busy=%b expected 0 0", done, busy);
      tests_failed++;
    end
  endtask

  task automatic test_write();
    issue(2'd1, 16'h2000, 16'hABCD);
    tests_run++;
    if (Data_rd !== 1'b0 || mem_state !== 2'b01 || Data_addr !== 16'h2000 || Data_din !== 16'hABCD) begin
      $display("FAIL write_phase: rd=%b ms=%b addr=%h din=%h expected 0 01 2000 abcd",
               Data_rd, mem_state, Data_addr, Data_din);
      tests_failed++;
    end
    complete_data = 1'b1;
    Data_dout     = 16'h1111;
    tick();
    complete_data = 1'b0;
    tests_run++;
    if (done !== 1'b1 || memout !== 16'hBEEF || Data_rd !== 1'b1) begin
      $display("FAIL write_done: done=%b memout=%h rd=%b expected 1 beef 1", done, memout, Data_rd);
      tests_failed++;
    end
    tick();
  endtask

  task automatic test_write_indirect();
    issue(2'd3, 16'h4000, 16'h1234);
    tests_run++;
    if (mem_state !== 2'b10 || Data_addr !== 16'h4000 || Data_rd !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL wind_ind: ms=%b addr=%h rd=%b busy=%b expected 10 4000 1 1",
               mem_state, Data_addr, Data_rd, busy);
      tests_failed++;
    end
    complete_data = 1'b1;
    Data_dout     = 16'h5000;
    tick();
    Data_dout = 16'h9999;
    tests_run++;
    if (Data_addr !== 16'h5000 || Data_din !== 16'h1234 || Data_rd !== 1'b0 || mem_state !== 2'b01) begin
      $display("FAIL wind_wr: addr=%h din=%h rd=%b ms=%b expected 5000 1234 0 01",
               Data_addr, Data_din, Data_rd, mem_state);
      tests_failed++;
    end
    tick();
    complete_data = 1'b0;
    tests_run++;
    if (done !== 1'b1 || memout !== 16'hBEEF) begin
      $display("FAIL wind_done: done=%b memout=%h expected 1 beef", done, memout);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL wind_idle: busy=%b done=%b expected 0 0", busy, done);
      tests_failed++;
    end
  endtask

  task automatic test_timeout();
    complete_data = 1'b0;
    issue(2'd0, 16'h3100, 16'h0000);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tests_run++;
      if (mem_state !== 2'b00 || error !== 1'b0 || done !== 1'b0) begin
        $display("FAIL timeout_wait%0d: ms=%b err=%b done=%b expected 00 0 0", i, mem_state, error, done);
        tests_failed++;
      end
      tick();
    end
    tests_run++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || memout !== 16'hBEEF) begin
      $display("FAIL timeout_err: err=%b done=%b busy=%b memout=%h expected 1 0 1 beef",
               error, done, busy, memout);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (error !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || memout !== 16'hBEEF) begin
      $display("FAIL timeout_after: err=%b busy=%b done=%b memout=%h expected 0 0 0 beef",
               error, busy, done, memout);
      tests_failed++;
    end
  endtask

  task automatic test_busy_start();
    issue(2'd0, 16'h3200, 16'h0000);
    start         = 1'b1;
    mem_op        = 2'd1;
    M_Addr        = 16'h7777;
    M_Data        = 16'h8888;
    complete_data = 1'b1;
    Data_dout     = 16'h0042;
    tick();
    complete_data = 1'b0;
    tests_run++;
    if (done !== 1'b1 || memout !== 16'h0042 || Data_addr !== 16'h3200) begin
      $display("FAIL busy_start_rd: done=%b memout=%h addr=%h expected 1 0042 3200",
               done, memout, Data_addr);
      tests_failed++;
    end
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || mem_state !== 2'b11 || Data_addr !== 16'h3200 || Data_din !== 16'h0000) begin
      $display("FAIL busy_start_done: busy=%b ms=%b addr=%h din=%h expected 0 11 3200 0000",
               busy, mem_state, Data_addr, Data_din);
      tests_failed++;
    end
    complete_data = 1'b1;
    Data_dout     = 16'hDEAD;
    tick();
    tick();
    complete_data = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || mem_state !== 2'b11 || done !== 1'b0 || memout !== 16'h0042) begin
      $display("FAIL idle_complete: busy=%b ms=%b done=%b memout=%h expected 0 11 0 0042",
               busy, mem_state, done, memout);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_op();
    issue(2'd2, 16'h4100, 16'h0000);
    tests_run++;
    if (mem_state !== 2'b10) begin
      $display("FAIL rst_mid_ind: ms=%b expected 10", mem_state);
      tests_failed++;
    end
    reset         = 1'b1;
    complete_data = 1'b1;
    Data_dout     = 16'h5555;
    tick();
    reset         = 1'b0;
    complete_data = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || memout !== 16'h0000 || mem_state !== 2'b11 || done !== 1'b0 || error !== 1'b0) begin
      $display("FAIL rst_mid_idle: busy=%b memout=%h ms=%b done=%b err=%b expected 0 0000 11 0 0",
               busy, memout, mem_state, done, error);
      tests_failed++;
    end
    tests_run++;
    if (Data_addr !== 16'h0000 || Data_rd !== 1'b1) begin
      $display("FAIL rst_mid_bus: addr=%h rd=%b expected 0000 1", Data_addr, Data_rd);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      $display("FAIL rst_mid_after: busy=%b done=%b err=%b expected 0 0 0", busy, done, error);
      tests_failed++;
    end
  endtask

  task automatic test_boundary();
    complete_data = 1'b0;
    issue(2'd0, 16'h3300, 16'h0000);
    tick();
    tick();
    tick();
    tests_run++;
    if (mem_state !== 2'b00 || error !== 1'b0) begin
      $display("FAIL boundary_rd4: ms=%b err=%b expected 00 0", mem_state, error);
      tests_failed++;
    end
    complete_data = 1'b1;
    Data_dout     = 16'hCAFE;
    tick();
    complete_data = 1'b0;
    tests_run++;
    if (done !== 1'b1 || error !== 1'b0 || memout !== 16'hCAFE) begin
      $display("FAIL boundary_done: done=%b err=%b memout=%h expected 1 0 cafe", done, error, memout);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      $display("FAIL boundary_idle: busy=%b err=%b expected 0 0", busy, error);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    start         = 1'b0;
    mem_op        = 2'd0;
    M_Addr        = '0;
    M_Data        = '0;
    complete_data = 1'b0;
    Data_dout     = '0;
    #2;
    test_reset();
    test_read();
    test_write();
    test_write_indirect();
    test_timeout();
    test_busy_start();
    test_reset_mid_op();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lc3_mem_sequencer.md
LC3_MEM_SEQUENCER -- requirements
Module: lc3_mem_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, address bus width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles per access phase; legal values are 1 or greater.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with the ports named clock and reset.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  request to begin an access.
- mem_op  in  2  access type: 0=read, 1=write, 2=read-indirect, 3=write-indirect.
- M_Addr  in  ADDR_W  access address, or pointer address for indirect ops.
- M_Data  in  DATA_W  store data.
- complete_data  in  1  memory has finished the current phase.
- Data_dout  in  DATA_W  memory read data.
- Data_addr  out  ADDR_W  memory address.
- Data_din  out  DATA_W  memory write data.
- Data_rd  out  1  1=read, 0=write strobe.
- mem_state  out  2  phase indicator: 00=read, 01=write, 10=indirect-address read, 11=idle.
- memout  out  DATA_W  last completed load value.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle timeout pulse.

Function
REQ-006 SHALL implement the FSM states IDLE, IND, RD, WR, DONE and ERR.
REQ-007 In IDLE with start=1, SHALL latch M_Addr into an address register and M_Data into a data register, then go to IND if mem_op[1]=1, else RD if mem_op=0, else WR.
REQ-008 SHALL ignore start in every state other than IDLE.
REQ-009 SHALL ignore complete_data in IDLE, DONE and ERR.
REQ-010 SHALL drive Data_addr from the address register and Data_din from the data register in all states.
REQ-011 SHALL drive Data_rd=0 only in WR; it SHALL be 1 in every other state.
REQ-012 SHALL drive mem_state as: IND->10, RD->00, WR->01, all other states->11.
REQ-013 In IND with complete_data=1, SHALL load Data_dout[ADDR_W-1:0] (zero-extended if ADDR_W>DATA_W) into the address register, then go to RD for a read-indirect op or WR for a write-indirect op.
REQ-014 In RD with complete_data=1, SHALL load Data_dout into memout and go to DONE.
REQ-015 In WR with complete_data=1, SHALL go to DONE.
REQ-016 SHALL update memout only on RD completion and SHALL otherwise hold its value.
REQ-017 SHALL assert done only in the DONE state, which lasts 1 cycle and then returns to IDLE.
REQ-018 A simple read SHALL have latency start->done of 2 cycles plus the memory wait cycles.
REQ-019 A wait counter of width $clog2(TIMEOUT+1) SHALL clear on entry to IND, RD and WR, and SHALL increment every cycle spent in that phase with complete_data=0.
REQ-020 If the counter reaches TIMEOUT-1 and complete_data=0, SHALL go to ERR.
REQ-021 complete_data SHALL be accepted in any of the first TIMEOUT cycles of a phase.
REQ-022 SHALL assert error only in ERR, which lasts 1 cycle, then return to IDLE with memout unchanged.
REQ-023 SHALL assert busy whenever state!=IDLE.

Reset
REQ-024 When reset=1 at a clock edge, SHALL go to IDLE and clear the address register, data register, memout and counter to 0; done=0, error=0, busy=0, Data_rd=1 and mem_state=11.
REQ-025 A reset during any active phase SHALL abort the access with no done or error pulse, and SHALL take precedence over start and complete_data in the same cycle.

Structure
REQ-026 The state encoding, the mem_op codes and the mem_state codes SHALL live in the shared definitions package/include alongside the existing LC3 data definitions.
REQ-027 SHALL be a single module with no sub-modules; the wait counter is inline.

Verification (DATA_W=16, ADDR_W=16, TIMEOUT=4)
REQ-028 Read: start, mem_op=0, M_Addr=0x3000, complete_data=1 in the first RD cycle with Data_dout=0xBEEF -> Data_rd=1, mem_state=00, then memout=0xBEEF and done=1 two cycles after start, then IDLE.
REQ-029 Write-indirect: mem_op=3, M_Addr=0x4000, M_Data=0x1234; IND completes with Data_dout=0x5000 -> WR phase shows Data_addr=0x5000, Data_din=0x1234, Data_rd=0, mem_state=01; complete -> done pulse, memout unchanged.
REQ-030 Timeout: read with complete_data held 0 -> 4 cycles in RD, then error=1 for 1 cycle, busy=0 afterwards, done never asserted.
REQ-031 Busy start: start=1 with mem_op=1 asserted during RD and during DONE -> ignored; no second access; complete_data pulsed in IDLE -> no state change.
REQ-032 Reset mid-op: reset=1 in IND of a read-indirect -> next cycle IDLE, memout=0, mem_state=11, no done or error pulse.
REQ-033 Boundary: complete_data arriving in the 4th RD cycle -> accepted, done=1 and error=0.
